// File: rtl/slt_operand_stage.sv
// Two-entry skid buffer staging (a, b) operand pairs in front of the SLT comparator.
// Optional transfer counter enabled by defining SLT_STAGE_CNT_EN.
module slt_operand_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_a,
  input  logic [n-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_a,
  output logic [n-1:0] out_b
`ifdef SLT_STAGE_CNT_EN
  ,
  output logic [n-1:0] xfer_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [n-1:0] s_a;
  logic [n-1:0] s_b;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // out_* and in_ready come straight from flops; M is out_a/out_b
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_a     <= '0;
      out_b     <= '0;
      s_a       <= '0;
      s_b       <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_a     <= in_a;
            out_b     <= in_b;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_a <= in_a;
            out_b <= in_b;
          end else if (in_xfer) begin
            s_a      <= in_a;
            s_b      <= in_b;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_a    <= s_a;
            out_b    <= s_b;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SLT_STAGE_CNT_EN
  // counts through flush; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_xfer) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_slt_operand_stage.sv
// Bench for slt_operand_stage: directed vector table plus random traffic
// checked against a queue model of the stage.
module tb_slt_operand_stage;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
`ifdef SLT_STAGE_CNT_EN
  logic [N-1:0] xfer_count;
  logic         w_iv, w_ir, w_ov, w_or;
  logic [3:0]   w_a, w_b, w_cnt;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  pair_t     q[$];
  logic [N-1:0] cnt;

  slt_operand_stage #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b)
`ifdef SLT_STAGE_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

`ifdef SLT_STAGE_CNT_EN
  slt_operand_stage #(.n(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_valid  (w_iv),
    .in_ready  (w_ir),
    .in_a      (4'd0),
    .in_b      (4'd0),
    .out_valid (w_ov),
    .out_ready (w_or),
    .out_a     (w_a),
    .out_b     (w_b),
    .xfer_count(w_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [N-1:0] got, logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Drive one cycle from a negedge; the model advances with the edge.
  task automatic step(bit iv, bit ordy, bit fl,
                      logic [N-1:0] a, logic [N-1:0] b);
    bit m_ov;
    bit m_ir;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_a      = a;
    in_b      = b;
    m_ov = (q.size() != 0);
    m_ir = (q.size() < 2);
    if (m_ov && ordy) cnt = cnt + 1;
    if (fl) begin
      q.delete();
    end else begin
      if (m_ov && ordy) void'(q.pop_front());
      if (iv && m_ir) q.push_back('{a: a, b: b});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      chk({tag, "_out_a"}, out_a, q[0].a);
      chk({tag, "_out_b"}, out_b, q[0].b);
    end
`ifdef SLT_STAGE_CNT_EN
    chk({tag, "_xfer_count"}, xfer_count, cnt);
`endif
  endtask

  typedef struct {
    bit           iv;
    bit           ordy;
    bit           fl;
    logic [N-1:0] a;
    logic [N-1:0] b;
    bit           eov;
    bit           eir;
    logic [N-1:0] ea;
    logic [N-1:0] eb;
  } vec_t;

  function automatic vec_t mk(bit iv, bit ordy, bit fl,
                              logic [N-1:0] a, logic [N-1:0] b,
                              bit eov, bit eir,
                              logic [N-1:0] ea, logic [N-1:0] eb);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl;
    v.a = a; v.b = b;
    v.eov = eov; v.eir = eir;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  initial begin
    vec_t tbl[17];
    logic [N-1:0] m8;
    checks   = 0;
    failures = 0;
    cnt      = '0;
    m8       = 32'hFFFF_FFF8;
`ifdef SLT_STAGE_CNT_EN
    w_iv = 1'b0;
    w_or = 1'b0;
`endif
    tbl[0]  = mk(1, 1, 0, 10, 4,  1, 1, 10, 4);
    tbl[1]  = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, m8, 10, 1, 1, m8, 10);
    tbl[3]  = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 4, 10,  1, 1, 4, 10);
    tbl[5]  = mk(1, 0, 0, 10, m8, 1, 0, 4, 10);
    tbl[6]  = mk(1, 0, 0, 8, 8,   1, 0, 4, 10);
    tbl[7]  = mk(1, 1, 0, 8, 8,   1, 1, 10, m8);
    tbl[8]  = mk(1, 1, 0, 8, 8,   1, 1, 8, 8);
    tbl[9]  = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 2,   1, 1, 1, 2);
    tbl[11] = mk(1, 0, 0, 3, 4,   1, 0, 1, 2);
    tbl[12] = mk(1, 0, 1, 5, 6,   0, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);
    tbl[14] = mk(1, 0, 0, 7, 7,   1, 1, 7, 7);
    tbl[15] = mk(1, 0, 1, 9, 9,   0, 1, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 10, 4);
    chk("preload_out_valid", {31'd0, out_valid}, 32'd1);

    // asynchronous reset mid-cycle with a pair buffered
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    q.delete();
    cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_out_a", out_a, 32'd0);
      chk("idle_out_b", out_b, 32'd0);
    end

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_out_valid", i),
          {31'd0, out_valid}, {31'd0, tbl[i].eov});
      chk($sformatf("vec%0d_in_ready", i),
          {31'd0, in_ready}, {31'd0, tbl[i].eir});
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_out_a", i), out_a, tbl[i].ea);
        chk($sformatf("vec%0d_out_b", i), out_b, tbl[i].eb);
      end
    end

`ifdef SLT_STAGE_CNT_EN
    chk("cnt_after5", xfer_count, 32'd5);
    step(1, 0, 1, 3, 3);
    chk("cnt_after_flush", xfer_count, 32'd5);
`endif

    // streaming: one pair per cycle, in_ready never drops
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, i, i + 100);
      chk($sformatf("stream%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("stream%0d_out_a", i), out_a, i);
      chk($sformatf("stream%0d_out_b", i), out_b, i + 100);
    end
    step(0, 1, 0, 0, 0);
    chk("stream_drain_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom, $urandom);
      chk_model("rand");
    end

`ifdef SLT_STAGE_CNT_EN
    // n=4 instance: stream until the counter wraps
    w_iv = 1'b1;
    w_or = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("wrap_cnt15", {28'd0, w_cnt}, 32'd15);
    @(negedge clk);
    chk("wrap_cnt0", {28'd0, w_cnt}, 32'd0);
    w_iv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slt_operand_stage.md
Name: slt_operand_stage

Overview:
- Registered operand staging buffer that sits directly upstream of the SLT comparator.
- Accepts (a, b) operand pairs from the operand source over a valid/ready handshake.
- Holds them in a 2-entry skid buffer and presents one pair at a time to the SLT inputs, also over a valid/ready handshake.
- Breaks the combinational path between the operand source and the comparator without losing throughput.

Parameters:
- n, 32, operand width in bits; matches the SLT width parameter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all buffered pairs
- in_valid  input  1  upstream pair available
- in_ready  output  1  stage can accept a pair this cycle
- in_a  input  n  operand a from upstream
- in_b  input  n  operand b from upstream
- out_valid  output  1  pair presented to SLT is valid
- out_ready  input  1  SLT side consumes the pair this cycle
- out_a  output  n  operand a to SLT port a
- out_b  output  n  operand b to SLT port b
- xfer_count  output  n  completed output transfers (only with SLT_STAGE_CNT_EN)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n), applied immediately and released synchronously.
- Reset values:
  - out_valid=0, in_ready=1, out_a=0, out_b=0.
  - Skid register cleared; xfer_count=0.
- Handshake rules:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready is driven from a register and never depends combinationally on out_ready.
  - out_a, out_b and out_valid are driven straight from the main register.
- Storage: main register (M) and skid register (S). Pairs leave in arrival order; no drop or duplicate.
- States:
  - EMPTY (M and S empty): in_ready=1, out_valid=0.
  - ONE (M full): in_ready=1, out_valid=1.
  - FULL (M and S full): in_ready=0, out_valid=1.
- Transitions from EMPTY:
  - Input transfer -> ONE; M <- input.
- Transitions from ONE:
  - Input and output transfer -> ONE; M <- input.
  - Input transfer only -> FULL; S <- input.
  - Output transfer only -> EMPTY.
  - Neither -> hold.
- Transitions from FULL:
  - Output transfer -> ONE; M <- S. No input is accepted because in_ready=0.
  - Otherwise hold.
- Latency: a pair accepted at edge k appears on out_a/out_b with out_valid=1 after edge k, when the stage was EMPTY.
- Throughput: one pair per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_a/out_b are held stable.
- Operands are passed bit-exact. No sign handling; the signed interpretation is the SLT's job.
- flush:
  - Highest priority. At the next edge the state becomes EMPTY, out_valid=0, in_ready=1.
  - An input transfer in the same cycle is discarded. An output transfer in the same cycle is still counted.
  - out_a/out_b data may retain stale values; consumers must qualify with out_valid.
- Reset mid-operation: all buffered pairs are discarded immediately, asynchronously.

Optional Feature:
- Macro: SLT_STAGE_CNT_EN.
- When defined:
  - xfer_count port exists.
  - Increments by 1 on every output transfer and wraps from 2^n-1 to 0.
  - Cleared only by rst_n; flush does not clear it.
- When undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> out_valid=0, in_ready=1, out_a=0, out_b=0 immediately. Holding in_valid=0 for 5 cycles keeps them there.
- Single pass, n=32:
  - Stimulus: in_a=10, in_b=4 with out_ready=1.
  - Required: out_valid=1 with out_a=10, out_b=4 one cycle later, then out_valid=0.
  - Repeat with a=-8 (0xFFFFFFF8), b=10 -> bits pass unchanged.
- Backpressure fill:
  - Stimulus: out_ready=0; offer (4,10), (10,-8), (8,8) back to back.
  - Required: first two accepted; in_ready=0 after the second; (8,8) is held upstream.
  - Raising out_ready drains (4,10), (10,-8), (8,8) in order.
- Streaming: out_ready=1 and in_valid=1 for 6 consecutive pairs 1..6 -> outputs 1..6 on consecutive cycles, in_ready stays 1.
- Flush in FULL with concurrent in_valid=1 -> next cycle EMPTY, out_valid=0, in_ready=1, and the concurrent pair never appears at the output.
- SLT_STAGE_CNT_EN:
  - After 5 output transfers -> xfer_count=5; a flush leaves it at 5.
  - Preload via 2^n-1 transfers (n=4 build) -> the next transfer wraps the count to 0.
